// File: rtl/gemm_pkg.sv
// Package shared by the GEMM core and the requantisation stage.
// It holds the FSM state type, the lane geometry and the default bus addresses.
package gemm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StWr,
    StDone
  } state_e;

  localparam int unsigned LANES  = 16;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned Q_W    = 8;
  localparam int unsigned GROUPS = 4;

  // Default word addresses shared with the GEMM core.
  localparam logic [63:0] IN_ADDR_DEFAULT  = 64'h400;
  localparam logic [63:0] OUT_ADDR_DEFAULT = 64'h200;

endpackage

// File: rtl/gemm_requant_if.sv
// Avalon master bus bundle used by gemm_requant.
// Signal names keep their direction suffixes as seen from the master side.
interface gemm_requant_if;
  logic [63:0]  AvalonAddr_o;
  logic         AvalonRead_o;
  logic         AvalonWrite_o;
  logic [63:0]  AvalonByteEnable_o;
  logic [511:0] AvalonWriteData_o;
  logic [511:0] AvalonReadData_i;
  logic         AvalonLock_o;
  logic         AvalonWaitReq_i;

  modport master (
    output AvalonAddr_o, AvalonRead_o, AvalonWrite_o, AvalonByteEnable_o,
    output AvalonWriteData_o, AvalonLock_o,
    input  AvalonReadData_i, AvalonWaitReq_i
  );

  modport slave (
    input  AvalonAddr_o, AvalonRead_o, AvalonWrite_o, AvalonByteEnable_o,
    input  AvalonWriteData_o, AvalonLock_o,
    output AvalonReadData_i, AvalonWaitReq_i
  );
endinterface

// File: rtl/requant_lane.sv
// One requantisation lane: rounding arithmetic right shift of an int32, saturated to int8.
// Optional macro GEMM_REQUANT_RELU_EN clamps negative results to zero.
module requant_lane
  import gemm_pkg::*;
(
  input  logic [ACC_W-1:0] i_acc,
  input  logic [4:0]       i_shift,
  output logic [Q_W-1:0]   o_q
);

  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_t;

  // Round half up in 33 bits so the rounding add can never overflow, then saturate.
  always_comb begin
    w_sum = $signed({i_acc[ACC_W-1], i_acc});
    if (i_shift != 5'd0) begin
      w_sum = w_sum + (33'sd1 <<< (i_shift - 5'd1));
    end
    w_t = w_sum >>> i_shift;
    if (w_t > 33'sd127) begin
      o_q = 8'h7F;
    end else if (w_t < -33'sd128) begin
      o_q = 8'h80;
    end else begin
      o_q = w_t[Q_W-1:0];
    end
`ifdef GEMM_REQUANT_RELU_EN
    if (o_q[Q_W-1]) begin
      o_q = '0;
    end
`endif
  end

endmodule

// File: rtl/gemm_requant.sv
// Post-GEMM requantisation: reads int32 accumulator lines over Avalon, quantises 16 lanes
// to int8 and packs four lines into each 512-bit output line.
// Optional macro GEMM_REQUANT_RELU_EN (see requant_lane) keeps only non-negative results.
module gemm_requant
  import gemm_pkg::*;
#(
  parameter logic [63:0] InAddr  = IN_ADDR_DEFAULT,
  parameter logic [63:0] OutAddr = OUT_ADDR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            Lines_i,
  input  logic [4:0]            Shift_i,
  input  logic                  CoreEnable_i,
  input  logic                  Req_i,
  output logic                  Ack_o,
  gemm_requant_if.master        bus
);

  localparam int unsigned LineW = LANES * Q_W;

  state_e                    r_state;
  logic [9:0]                r_lines;
  logic [9:0]                r_count;
  logic [4:0]                r_shift;
  logic [1:0]                r_group;
  logic [63:0]               r_rd_addr;
  logic [63:0]               r_wr_addr;
  logic [63:0]               r_addr;
  logic                      r_read;
  logic                      r_write;
  logic                      r_ack;
  logic [GROUPS*LineW-1:0]   r_buf;

  logic [LineW-1:0]          w_q;
  logic [GROUPS*LineW-1:0]   w_buf_next;
  logic                      w_last;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    requant_lane u_lane (
      .i_acc   (bus.AvalonReadData_i[ACC_W*k +: ACC_W]),
      .i_shift (r_shift),
      .o_q     (w_q[Q_W*k +: Q_W])
    );
  end

  // Drop the freshly quantised line into its group slot of the pack buffer.
  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[r_group*LineW +: LineW] = w_q;
    w_last = (r_count + 10'd1 == r_lines);
  end

  // Job sequencer with registered bus outputs; the pack buffer doubles as write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_lines   <= '0;
      r_count   <= '0;
      r_shift   <= '0;
      r_group   <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_addr    <= '0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_ack     <= 1'b0;
      r_buf     <= '0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (Req_i && CoreEnable_i) begin
            r_lines   <= Lines_i;
            r_shift   <= Shift_i;
            r_rd_addr <= InAddr;
            r_wr_addr <= OutAddr;
            r_group   <= '0;
            r_count   <= '0;
            r_buf     <= '0;
            if (Lines_i == 10'd0) begin
              r_state <= StDone;
            end else begin
              r_state <= StRd;
              r_read  <= 1'b1;
              r_addr  <= InAddr;
            end
          end
        end
        StRd: begin
          if (!bus.AvalonWaitReq_i) begin
            r_read  <= 1'b0;
            r_state <= StCap;
          end
        end
        StCap: begin
          r_buf     <= w_buf_next;
          r_rd_addr <= r_rd_addr + 64'd1;
          r_count   <= r_count + 10'd1;
          if (r_group == 2'(GROUPS - 1) || w_last) begin
            r_state <= StWr;
            r_write <= 1'b1;
            r_addr  <= r_wr_addr;
          end else begin
            r_group <= r_group + 2'd1;
            r_state <= StRd;
            r_read  <= 1'b1;
            r_addr  <= r_rd_addr + 64'd1;
          end
        end
        StWr: begin
          if (!bus.AvalonWaitReq_i) begin
            r_write   <= 1'b0;
            r_wr_addr <= r_wr_addr + 64'd1;
            r_group   <= '0;
            r_buf     <= '0;
            if (r_count == r_lines) begin
              r_state <= StDone;
            end else begin
              r_state <= StRd;
              r_read  <= 1'b1;
              r_addr  <= r_rd_addr;
            end
          end
        end
        StDone: begin
          r_ack   <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign Ack_o                  = r_ack;
  assign bus.AvalonAddr_o       = r_addr;
  assign bus.AvalonRead_o       = r_read;
  assign bus.AvalonWrite_o      = r_write;
  assign bus.AvalonByteEnable_o = '1;
  assign bus.AvalonWriteData_o  = r_buf;
  assign bus.AvalonLock_o       = r_read | r_write;

endmodule

// File: doc/gemm_requant.md
# gemm_requant

Post-GEMM requantisation stage that runs after the GEMM core on the shared Avalon bus. Reads the 32-bit accumulator lines the GEMM core leaves in shared memory. Each lane gets a rounding arithmetic right shift and is saturated to int8. Four accumulator lines (64 int8 values) are packed into each 512-bit line and written back as the next layer's input feature map.

## Interface
Parameters:
- InAddr, 64'h400: word address of the first accumulator line to read.
- OutAddr, 64'h200: word address of the first packed int8 line to write.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- Lines_i  in  10  number of accumulator lines to process; sampled on start.
- Shift_i  in  5  right-shift amount, 0..31; sampled on start.
- CoreEnable_i  in  1  block enable; start = Req_i && CoreEnable_i.
- Req_i  in  1  job request.
- Ack_o  out  1  one-cycle done pulse.
- AvalonAddr_o  out  64  word address.
- AvalonRead_o  out  1  read request.
- AvalonWrite_o  out  1  write request.
- AvalonByteEnable_o  out  64  tied all-ones.
- AvalonWriteData_o  out  512  packed int8 line.
- AvalonReadData_i  in  512  16 x int32 accumulators; lane k = bits [32k+31:32k].
- AvalonLock_o  out  1  = AvalonRead_o | AvalonWrite_o.
- AvalonWaitReq_i  in  1  slave stall.

## Operation
- FSM states: IDLE, RD, CAP, WR, DONE.
- IDLE
  - On start, latch Lines_i and Shift_i.
  - Set rd_addr = InAddr, wr_addr = OutAddr, group = 0, line count = 0.
  - Clear the pack buffer.
  - Go to RD; if Lines_i == 0, go to DONE instead (no bus traffic).
- RD
  - AvalonRead_o = 1, AvalonAddr_o = rd_addr.
  - Hold until the cycle where AvalonWaitReq_i = 0 (accepted), then go to CAP.
- CAP
  - Read data is valid this cycle (fixed read latency 1).
  - Quantise all 16 lanes; write the resulting 16 bytes into pack buffer bytes [16*group +: 16].
  - Increment rd_addr and line count.
  - If group == 3 or this is the last line, go to WR; otherwise group += 1 and go to RD.
- WR
  - AvalonWrite_o = 1, AvalonAddr_o = wr_addr, AvalonWriteData_o = pack buffer.
  - Hold until AvalonWaitReq_i = 0.
  - Then wr_addr += 1, group = 0, clear the pack buffer.
  - Go to DONE if all lines are consumed, else RD.
- DONE: Ack_o = 1 for exactly one cycle, then IDLE.
- Quantisation per lane, with acc signed 32-bit:
  - If Shift > 0: t = (sext33(acc) + (1 << (Shift-1))) >>> Shift. If Shift == 0: t = acc.
  - Saturate t to [-128, 127]; the byte is the two's-complement result.
- Partial final group (Lines not a multiple of 4): unfilled byte groups are written as 0x00.
- Output lines written = ceil(Lines/4).
- Req_i is ignored outside IDLE.
- Lines_i and Shift_i changes after start have no effect on the running job.

## Timing
- Reset values: Ack_o 0, AvalonRead_o 0, AvalonWrite_o 0, AvalonAddr_o 0, AvalonWriteData_o 0, state IDLE.
- Reset mid-job drops any request on the next edge; no further bus activity until a new start.
- All Avalon outputs are registered and stable while AvalonWaitReq_i = 1.
- Read and write are never asserted in the same cycle; at most one outstanding read.
- With no stalls: RD 1 + CAP 1 per line; WR 1 per output line.
  - A full output line costs 9 cycles; Lines = 16 completes in 36 cycles + DONE.
- Start in IDLE puts AvalonRead_o high on the next cycle.

## Configuration
- GEMM_REQUANT_RELU_EN defined: after saturation, negative results become 0 (output range [0, 127]).
- Undefined: signed range [-128, 127] is kept.

## Structure
- Shared package gemm_pkg holds:
  - state enum.
  - LANES = 16, ACC_W = 32, Q_W = 8, GROUPS = 4.
  - default address constants shared with the GEMM core.
- Sub-module requant_lane: combinational, one int32 plus shift to int8, honours the macro. Instantiated 16 times.

## Test plan
- Lines = 4, Shift = 0, lane values 5, -3, 200, -200 -> one write at 0x200; bytes 0x05, 0xFD, 0x7F, 0x80 in the lane positions; Ack pulse.
- Shift = 4, acc = 24 -> 2 (rounding: (24+8)>>4); acc = -24 -> -1 (0xFF); acc = 0x7FFFFFFF -> 0x7F.
- Lines = 6 -> two writes at 0x200 and 0x201; the second line's bytes 32..63 are 0x00; reads cover 0x400..0x405 in order.
- AvalonWaitReq_i high for 3 cycles during RD and during WR -> address and data held constant; no duplicate captures; results identical to the no-stall run.
- Lines = 0 -> no Read or Write ever asserted; Ack_o pulses 2 cycles after start.
- rst asserted in WR -> Write drops next cycle, no Ack; a new Req then restarts from 0x400 / 0x200.
